load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, sampled on the rising edge of clk: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 Pipeline-side ports SHALL be: valid_i in 1, memory op present; we_i in 1, 1=store 0=load; dex_i in 3, width/extend code (000 b, 001 h, 010 w, 100 bu, 101 hu); addr_i in 32, byte address; wdata_i in 32, store data.
REQ-003 Pipeline results SHALL be: stall_o out 1, hold pipeline; done_o out 1, op complete pulse; rdata_o out 32, extended load data; misalign_o out 1, alignment/code fault; timeout_o out 1, bus timeout fault.
REQ-004 Bus-side ports SHALL be: mem_req out 1; mem_we out 1; mem_addr out 32, word-aligned; mem_wstrb out 4; mem_wdata out 32; mem_ack in 1; mem_rdata in 32, valid in the mem_ack cycle.
REQ-005 Parameter TIMEOUT SHALL default to 16 and set the maximum bus-wait cycles.

Function
REQ-006 The FSM SHALL have states IDLE, BUS, DONE.
REQ-007 In IDLE with valid_i=1, the block SHALL latch we_i, dex_i, addr_i and wdata_i and go to BUS if aligned, or to DONE with misalign_o set if not.
REQ-008 Misaligned means: h/hu with addr_i[0]=1, w with addr_i[1:0]!=0, or dex_i in {011,110,111}; no bus transaction SHALL be issued.
REQ-009 In BUS, mem_req SHALL be 1 and mem_addr, mem_we, mem_wstrb and mem_wdata SHALL be driven from registers and held stable until the mem_ack cycle.
REQ-010 mem_addr SHALL equal {latched addr[31:2], 2'b00}.
REQ-011 mem_wstrb SHALL be 0001<<off for b, 0011<<off for h and 1111 for w, where off=addr[1:0]; it SHALL be 0000 for loads.
REQ-012 mem_wdata SHALL be {4{wdata[7:0]}} for b, {2{wdata[15:0]}} for h and wdata for w.
REQ-013 On mem_ack in BUS, a load SHALL register rdata_o = extend(mem_rdata >> 8*off): b/h sign-extend, bu/hu zero-extend, w unchanged; the FSM SHALL go to DONE.
REQ-014 A wait counter SHALL clear on entry to BUS and increment every BUS cycle without ack; if ack has not arrived after TIMEOUT cycles, the FSM SHALL drop mem_req, set timeout_o and go to DONE.
REQ-015 An ack in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-016 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE; a new op SHALL NOT be accepted in DONE.
REQ-017 stall_o SHALL be combinational: valid_i & (state!=DONE).
REQ-018 The pipeline SHALL be allowed to change inputs only after done_o, and the block SHALL ignore input changes while in BUS.
REQ-019 rdata_o, misalign_o and timeout_o SHALL hold their values from DONE until the next op is accepted.
REQ-020 For stores and faults, rdata_o SHALL be 0.
REQ-021 mem_ack outside BUS SHALL be ignored.
REQ-022 Minimum load/store latency SHALL be: accept cycle, 1 BUS cycle with ack, 1 DONE cycle, i.e. done_o 2 cycles after acceptance.

Reset
REQ-023 While rst=1, at the next clk edge: state=IDLE, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, done_o=0, rdata_o=0, misalign_o=0, timeout_o=0, counter=0.
REQ-024 Reset asserted in BUS SHALL abort the transaction, drop mem_req at that edge and produce no done_o.
REQ-025 A late mem_ack after reset SHALL be ignored.

Verification
REQ-026 lb at addr 0x1003, ack 1 cycle later with mem_rdata=0x80FF_FF00 -> mem_addr=0x1000, done_o 2 cycles after accept, rdata_o=0xFFFF_FF80.
REQ-027 lhu at addr 0x2002, mem_rdata=0xBEEF_1234 -> rdata_o=0x0000_BEEF; lh at the same address -> rdata_o=0xFFFF_BEEF.
REQ-028 sh at addr 0x3002 with wdata=0x1234_ABCD -> mem_wstrb=1100, mem_wdata=0xABCD_ABCD, mem_we=1, rdata_o=0.
REQ-029 lw at addr 0x4001 -> mem_req never asserts, done_o 1 cycle after accept, misalign_o=1; dex_i=011 behaves the same.
REQ-030 sw with mem_ack held low -> mem_req high for 16 cycles, then timeout_o=1 and done_o=1; ack on exactly the 16th cycle -> timeout_o=0.
REQ-031 rst asserted on the 3rd BUS cycle, then mem_ack pulsed -> mem_req=0 after the edge, no done_o, all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit (master) and memory (slave).
// One request is held open until the memory acknowledges it.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns and formats byte/half/word accesses
// onto a word bus, extends load data, and flags misalignment and bus timeouts.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        we_i,
    input  logic [2:0]  dex_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        timeout_o,
    load_store_unit_if.master mem
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          we_q;
    logic [2:0]    dex_q;
    logic [1:0]    off_q;

    logic          accept;
    logic          misalign;
    logic          expired;
    logic [3:0]    wstrb_nxt;
    logic [31:0]   wdata_nxt;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;

    assign accept  = (state == IDLE) && valid_i;
    assign expired = (wait_cnt == CW'(TIMEOUT - 1));
    assign stall_o = valid_i && (state != DONE);
    assign done_o  = (state == DONE);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        misalign = 1'b1;
        case (dex_i)
            3'b000, 3'b100: misalign = 1'b0;
            3'b001, 3'b101: misalign = addr_i[0];
            3'b010:         misalign = |addr_i[1:0];
            default:        misalign = 1'b1;
        endcase
    end

    // Store lanes: data is replicated so the strobes alone pick the target bytes.
    always_comb begin
        wstrb_nxt = 4'b1111;
        wdata_nxt = wdata_i;
        case (dex_i[1:0])
            2'b00: begin
                wstrb_nxt = 4'b0001 << addr_i[1:0];
                wdata_nxt = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                wstrb_nxt = 4'b0011 << addr_i[1:0];
                wdata_nxt = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
        if (!we_i)
            wstrb_nxt = 4'b0000;
    end

    always_comb begin
        shifted  = mem.mem_rdata >> {off_q, 3'b000};
        load_ext = mem.mem_rdata;
        case (dex_q[1:0])
            2'b00:   load_ext = {{24{~dex_q[2] & shifted[7]}},  shifted[7:0]};
            2'b01:   load_ext = {{16{~dex_q[2] & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i) state_nxt = misalign ? DONE : BUS;
            BUS:     if (mem.mem_ack || expired) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wstrb <= '0;
            mem.mem_wdata <= '0;
            rdata_o       <= '0;
            misalign_o    <= 1'b0;
            timeout_o     <= 1'b0;
            wait_cnt      <= '0;
            we_q          <= 1'b0;
            dex_q         <= '0;
            off_q         <= '0;
        end else if (accept) begin
            we_q       <= we_i;
            dex_q      <= dex_i;
            off_q      <= addr_i[1:0];
            rdata_o    <= '0;
            misalign_o <= misalign;
            timeout_o  <= 1'b0;
            wait_cnt   <= '0;
            if (!misalign) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= we_i;
                mem.mem_addr  <= {addr_i[31:2], 2'b00};
                mem.mem_wstrb <= wstrb_nxt;
                mem.mem_wdata <= wdata_nxt;
            end
        end else if (state == BUS) begin
            // An ack in the final wait cycle wins over the timeout.
            if (mem.mem_ack) begin
                mem.mem_req <= 1'b0;
                if (!we_q)
                    rdata_o <= load_ext;
            end else if (expired) begin
                mem.mem_req <= 1'b0;
                timeout_o   <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus scoreboard queue,
// and hand sequences for DONE behaviour and reset during a bus wait.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        we_i;
    logic [2:0]  dex_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        timeout_o;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .we_i       (we_i),
        .dex_i      (dex_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .misalign_o (misalign_o),
        .timeout_o  (timeout_o),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  dex;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        logic [31:0] x_addr;
        logic [3:0]  x_strb;
        logic [31:0] x_wdata;
        logic [31:0] x_rdata;
        logic        x_mis;
        logic        x_to;
        int          x_lat;
        int          x_req;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[18];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] dex, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at,
                                input logic [31:0] x_addr, input logic [3:0] x_strb,
                                input logic [31:0] x_wdata, input logic [31:0] x_rdata,
                                input logic x_mis, input logic x_to, input int x_lat, input int x_req);
        vec_t v;
        v.we = we; v.dex = dex; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.ack_at = ack_at; v.x_addr = x_addr; v.x_strb = x_strb; v.x_wdata = x_wdata;
        v.x_rdata = x_rdata; v.x_mis = x_mis; v.x_to = x_to; v.x_lat = x_lat; v.x_req = x_req;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one op, play the memory side, and score the result when done_o appears.
    task automatic run_op(input int idx, input vec_t v);
        int          ncyc;
        int          nreq;
        bit          seen;
        bit          moved;
        logic [31:0] a0;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic        w0;
        vec_t        e;
        sb.push_back(v);
        valid_i = 1'b1;
        we_i    = v.we;
        dex_i   = v.dex;
        addr_i  = v.addr;
        wdata_i = v.wdata;
        #1;
        check($sformatf("v%0d_stall", idx), 32'(stall_o), 32'd1);
        ncyc = 0; nreq = 0; seen = 1'b0; moved = 1'b0;
        a0 = '0; s0 = '0; d0 = '0; w0 = 1'b0;
        while (!seen && ncyc < 64) begin
            step();
            ncyc++;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'hDEAD_BEEF;
            if (bus.mem_req) begin
                nreq++;
                if (nreq == 1) begin
                    a0 = bus.mem_addr; s0 = bus.mem_wstrb; d0 = bus.mem_wdata; w0 = bus.mem_we;
                    check($sformatf("v%0d_addr", idx), bus.mem_addr, sb[0].x_addr);
                    check($sformatf("v%0d_we", idx), 32'(bus.mem_we), 32'(sb[0].we));
                    check($sformatf("v%0d_strb", idx), 32'(bus.mem_wstrb), 32'(sb[0].x_strb));
                    if (sb[0].we)
                        check($sformatf("v%0d_wdata", idx), bus.mem_wdata, sb[0].x_wdata);
                end else if (a0 !== bus.mem_addr || s0 !== bus.mem_wstrb ||
                             d0 !== bus.mem_wdata || w0 !== bus.mem_we) begin
                    moved = 1'b1;
                end
                if (nreq == v.ack_at) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = v.rdata;
                end
            end
            if (done_o)
                seen = 1'b1;
        end
        e = sb.pop_front();
        check($sformatf("v%0d_done_seen", idx), 32'(seen), 32'd1);
        check($sformatf("v%0d_latency", idx), 32'(ncyc), 32'(e.x_lat));
        check($sformatf("v%0d_req_cycles", idx), 32'(nreq), 32'(e.x_req));
        check($sformatf("v%0d_bus_stable", idx), 32'(moved), 32'd0);
        check($sformatf("v%0d_rdata", idx), rdata_o, e.x_rdata);
        check($sformatf("v%0d_misalign", idx), 32'(misalign_o), 32'(e.x_mis));
        check($sformatf("v%0d_timeout", idx), 32'(timeout_o), 32'(e.x_to));
        valid_i = 1'b0;
        step();
        check($sformatf("v%0d_done_one_cycle", idx), 32'(done_o), 32'd0);
        check($sformatf("v%0d_rdata_hold", idx), rdata_o, e.x_rdata);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_req"},   32'(bus.mem_req), 32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we), 32'd0);
        check({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_done"},      32'(done_o), 32'd0);
        check({tag, "_rdata"},     rdata_o, 32'd0);
        check({tag, "_misalign"},  32'(misalign_o), 32'd0);
        check({tag, "_timeout"},   32'(timeout_o), 32'd0);
    endtask

    initial begin
        int dones;
        int nreq;

        //          we    dex     addr          wdata         rdata        ack  x_addr        strb     x_wdata       x_rdata       mis   to    lat req
        vecs[0]  = mk(1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 1, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 2,  1);
        vecs[1]  = mk(1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 1, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_BEEF, 1'b0, 1'b0, 2,  1);
        vecs[2]  = mk(1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 1, 32'h0000_2000, 4'b0000, 32'h0,        32'hFFFF_BEEF, 1'b0, 1'b0, 2,  1);
        vecs[3]  = mk(1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h5555_5555, 3, 32'h0000_3000, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0, 4,  3);
        vecs[4]  = mk(1'b0, 3'b010, 32'h0000_4001, 32'h0,        32'h0,         1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1,  0);
        vecs[5]  = mk(1'b0, 3'b011, 32'h0000_4000, 32'h0,        32'h0,         1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1,  0);
        vecs[6]  = mk(1'b1, 3'b010, 32'h0000_5000, 32'hCAFE_F00D, 32'h0,         0, 32'h0000_5000, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b1, 17, 16);
        vecs[7]  = mk(1'b1, 3'b010, 32'h0000_5004, 32'h0102_0304, 32'h0,        16, 32'h0000_5004, 4'b1111, 32'h0102_0304, 32'h0,        1'b0, 1'b0, 17, 16);
        vecs[8]  = mk(1'b0, 3'b100, 32'h0000_6001, 32'h0,        32'h1234_8056, 2, 32'h0000_6000, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 3,  2);
        vecs[9]  = mk(1'b0, 3'b000, 32'h0000_6000, 32'h0,        32'h0000_007F, 1, 32'h0000_6000, 4'b0000, 32'h0,        32'h0000_007F, 1'b0, 1'b0, 2,  1);
        vecs[10] = mk(1'b1, 3'b000, 32'h0000_7002, 32'h0000_00A5, 32'h0,         1, 32'h0000_7000, 4'b0100, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0, 2,  1);
        vecs[11] = mk(1'b0, 3'b010, 32'h0000_8000, 32'h0,        32'h89AB_CDEF, 2, 32'h0000_8000, 4'b0000, 32'h0,        32'h89AB_CDEF, 1'b0, 1'b0, 3,  2);
        vecs[12] = mk(1'b0, 3'b001, 32'h0000_8001, 32'h0,        32'h0,         1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1,  0);
        vecs[13] = mk(1'b0, 3'b110, 32'h0000_8000, 32'h0,        32'h0,         1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1,  0);
        vecs[14] = mk(1'b1, 3'b111, 32'h0000_9000, 32'h1111_2222, 32'h0,         1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1,  0);
        vecs[15] = mk(1'b0, 3'b001, 32'h0000_9000, 32'h0,        32'h1234_8001, 1, 32'h0000_9000, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0, 2,  1);
        vecs[16] = mk(1'b0, 3'b010, 32'h0000_A000, 32'h0,        32'h0,         0, 32'h0000_A000, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 17, 16);
        vecs[17] = mk(1'b1, 3'b001, 32'h0000_B000, 32'h0000_BEEF, 32'h0,         1, 32'h0000_B000, 4'b0011, 32'hBEEF_BEEF, 32'h0,        1'b0, 1'b0, 2,  1);

        rst = 1'b1; valid_i = 1'b0; we_i = 1'b0; dex_i = 3'b000;
        addr_i = '0; wdata_i = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        step();
        step();
        check_reset_values("reset");
        check("reset_stall", 32'(stall_o), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 18; i++)
            run_op(i, vecs[i]);

        // valid_i held through DONE: the op must not be re-accepted there.
        valid_i = 1'b1; we_i = 1'b0; dex_i = 3'b010; addr_i = 32'h0000_4002; wdata_i = '0;
        step();
        check("hold_done", 32'(done_o), 32'd1);
        check("hold_stall_in_done", 32'(stall_o), 32'd0);
        step();
        check("hold_done_dropped", 32'(done_o), 32'd0);
        check("hold_no_req", 32'(bus.mem_req), 32'd0);
        valid_i = 1'b0;
        step();
        check("hold_idle_done", 32'(done_o), 32'd0);

        // Reset on the third bus-wait cycle, then a stray ack.
        valid_i = 1'b1; we_i = 1'b1; dex_i = 3'b010; addr_i = 32'h0000_C000; wdata_i = 32'h1357_9BDF;
        nreq = 0;
        for (int c = 0; c < 10 && nreq < 3; c++) begin
            step();
            if (bus.mem_req) nreq++;
        end
        check("rstbus_reached_wait", 32'(nreq), 32'd3);
        rst = 1'b1;
        step();
        check_reset_values("rstbus");
        rst = 1'b0; valid_i = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        dones = 0;
        step();
        if (done_o) dones++;
        bus.mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done_o) dones++;
        end
        check("rstbus_no_done", 32'(dones), 32'd0);
        check_reset_values("late_ack");

        run_op(18, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
